// File: rtl/pll_lock_sequencer.sv
// PLL start-up sequencer: holds the PLL in reset, qualifies LOCK, then releases the system reset.
// Lock timeouts are retried a bounded number of times before FAULT; lock loss in RUN restarts the sequence.
module pll_lock_sequencer #(
  parameter int RESET_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int BYPASS_ON_FAULT     = 1
) (
  input  logic                             clk_i,
  input  logic                             sreset_i,
  input  logic                             pll_lock_i,
  input  logic                             restart_i,
  output logic                             pll_resetb_o,
  output logic                             pll_bypass_o,
  output logic                             sys_reset_o,
  output logic                             locked_o,
  output logic                             fault_o,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count_o
);

  localparam int MAX_AB = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAXC   = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW     = $clog2(MAXC) + 1;
  localparam int RW     = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_END  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] STAB_END = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_END   = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_STAB  = 3'd2,
    S_RUN   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [1:0]      sync_q;
  logic            lock_s;
  logic            enter;

  logic pll_resetb_q, pll_resetb_d;
  logic pll_bypass_q, pll_bypass_d;
  logic sys_reset_q,  sys_reset_d;
  logic locked_q,     locked_d;
  logic fault_q,      fault_d;

  // LOCK is asynchronous to the reference clock
  always_ff @(posedge clk_i) begin
    if (sreset_i) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], pll_lock_i};
  end
  assign lock_s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (sreset_i) begin
      state_q      <= S_RESET;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_resetb_q <= 1'b0;
      pll_bypass_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_resetb_q <= pll_resetb_d;
      pll_bypass_q <= pll_bypass_d;
      sys_reset_q  <= sys_reset_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    enter   = 1'b0;
    unique case (state_q)
      S_RESET: if (cnt_q == RST_END) begin
        state_d = S_WAIT;
        enter   = 1'b1;
      end
      // lock wins over a coincident timeout
      S_WAIT: if (lock_s) begin
        state_d = S_STAB;
        enter   = 1'b1;
      end else if (cnt_q == TO_END) begin
        retry_d = retry_q + RW'(1);
        state_d = (retry_d == RETRY_MAX) ? S_FAULT : S_RESET;
        enter   = 1'b1;
      end
      S_STAB: if (!lock_s) begin
        state_d = S_WAIT;
        enter   = 1'b1;
      end else if (cnt_q == STAB_END) begin
        state_d = S_RUN;
        retry_d = '0;
        enter   = 1'b1;
      end
      S_RUN: if (!lock_s) begin
        state_d = S_RESET;
        enter   = 1'b1;
      end
      S_FAULT: ;
      default: begin
        state_d = S_RESET;
        enter   = 1'b1;
      end
    endcase
    if (restart_i) begin
      state_d = S_RESET;
      retry_d = '0;
      enter   = 1'b1;
    end
    if (enter)
      cnt_d = '0;
    else if (state_q == S_RESET || state_q == S_WAIT || state_q == S_STAB)
      cnt_d = cnt_q + CW'(1);
    else
      cnt_d = cnt_q;
  end

  // Outputs are decoded from the next state so they change on the entry edge
  always_comb begin
    pll_resetb_d = 1'b0;
    pll_bypass_d = 1'b0;
    sys_reset_d  = 1'b1;
    locked_d     = 1'b0;
    fault_d      = 1'b0;
    unique case (state_d)
      S_RESET: ;
      S_WAIT, S_STAB: pll_resetb_d = 1'b1;
      S_RUN: begin
        pll_resetb_d = 1'b1;
        sys_reset_d  = 1'b0;
        locked_d     = 1'b1;
      end
      S_FAULT: begin
        fault_d      = 1'b1;
        pll_bypass_d = (BYPASS_ON_FAULT != 0);
        sys_reset_d  = (BYPASS_ON_FAULT == 0);
      end
      default: ;
    endcase
  end

  assign pll_resetb_o  = pll_resetb_q;
  assign pll_bypass_o  = pll_bypass_q;
  assign sys_reset_o   = sys_reset_q;
  assign locked_o      = locked_q;
  assign fault_o       = fault_q;
  assign retry_count_o = retry_q;

endmodule
